alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
// Issuing side of the datapath ALU interface: accepts one instruction at a time over a
// valid/ready handshake, reads operands from an internal register file, drives the ALU's
// a/b/cin/operation inputs, samples sum/cout, and writes back the result and flags.
// Sits between the instruction fetch/decode front end and the combinational ALU.
// PARAMETERS
// DATA_W  8   operand/result width; must match the ALU width
// NREGS   4   register file depth; the address is 2 bits at the default
// OP_W    4   ALU operation code width
// PORTS
// clk          in   1       single clock, rising edge
// rst_n        in   1       asynchronous, active-low reset
// instr_valid  in   1       instruction present
// instr_ready  out  1       block can accept an instruction (IDLE only)
// instr        in   16      [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm
// alu_a        out  DATA_W  operand A = R[rd] (registered)
// alu_b        out  DATA_W  operand B = R[rs] (registered)
// alu_cin      out  1       1 for SUB, 0 otherwise
// alu_op       out  OP_W    ALU code: 0001 SUB, 0010 ADD, 0101 XOR, 0011 AND
// alu_sum      in   DATA_W  ALU result (combinational from alu_a/alu_b/alu_op)
// alu_cout     in   1       ALU carry out
// res_valid    out  1       1-cycle pulse on register writeback
// res_rd       out  2       destination of the writeback
// res_data     out  DATA_W  value written
// flag_z       out  1       zero flag
// flag_c       out  1       carry flag
// err          out  1       1-cycle pulse on an illegal opcode
// dbg_addr     in   2       register file debug read address
// dbg_data     out  DATA_W  R[dbg_addr], combinational
// BEHAVIOUR
// - Clock and reset: single clock; reset is asynchronous and active-low.
// - Reset (async, rst_n=0): FSM=IDLE; all R[i]=0; alu_a=alu_b=0; alu_op=0; alu_cin=0.
//   Reset also clears res_valid, res_rd, res_data, flag_z, flag_c and err.
//   instr_ready is 1 from the first edge after rst_n rises.
//   Reset during ISSUE or WB abandons the instruction: no writeback, no pulse.
// - Opcodes: 0001 SUB, 0010 ADD, 0101 XOR, 0011 AND (ALU ops; rd <= rd op rs).
//   1000 LDI (rd <= imm). 1111 NOP. Any other code is illegal.
// - FSM states: IDLE, ISSUE, WB.
// - IDLE: instr_ready=1. On instr_valid&&instr_ready, instr is latched.
//   ALU op: register alu_a/alu_b/alu_op/alu_cin, then go to ISSUE.
//   LDI: go to WB with result=imm.
//   NOP: stay in IDLE; nothing changes.
//   Illegal: err=1 for the next cycle; stay in IDLE; registers and flags unchanged.
// - ISSUE: instr_ready=0. alu_* are stable for the whole cycle.
//   At the closing edge, sample alu_sum into result and alu_cout into a carry temp.
//   Go to WB.
// - WB: instr_ready=0. R[rd]<=result at the closing edge.
//   res_valid=1 during WB, with res_rd/res_data driven.
//   flag_z <= (result==0) on every writeback.
//   flag_c <= sampled alu_cout for ADD/SUB; 0 for XOR/AND; unchanged for LDI.
//   Go to IDLE.
// - Latency from the handshake edge to res_valid: ALU op 2 cycles (ISSUE, then WB).
//   LDI: 1 cycle.
// - Throughput: one ALU op per 3 cycles; one LDI per 2 cycles.
// - instr and instr_valid are ignored while instr_ready=0; no queuing.
// - Operand hazards: none. Writeback completes before the next accept.
// - rd==rs is legal; both operands read the same register value.
// - alu_a/alu_b/alu_op hold their last values outside ISSUE.
// - Arithmetic is mod 2^DATA_W; the carry is taken only from alu_cout.
// - dbg_data reflects a writeback from the edge that ends WB.
// TESTING
// 1 Reset: drop rst_n mid-ISSUE of ADD -> no res_valid; all outputs 0; instr_ready=1 after release.
// 2 LDI R0,05; LDI R1,03; ADD R0,R1 -> res_valid with rd=0, data=0x08; z=0; c=0; dbg R0=0x08.
// 3 LDI R2,FF; LDI R3,01; ADD R2,R3 -> data=0x00; z=1; c=1. SUB R0,R0 -> 0x00, z=1, alu_cin=1.
// 4 LDI R1,F0; LDI R2,FF; XOR R1,R2 -> 0x0F, c=0. AND R1,R2 -> 0x0F; alu_op=0011 during ISSUE.
// 5 instr_valid held high, 4 ADDs -> handshakes 3 cycles apart; instr changes during ISSUE/WB ignored.
// 6 op=0111 -> err pulses 1 cycle, no res_valid, regs/flags unchanged. NOP -> no pulse, ready stays 1.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Issue controller for a combinational ALU. It accepts one
//               instruction at a time, reads operands from a small register
//               file, drives the ALU inputs, samples the ALU result and carry,
//               and writes back the result and the zero/carry flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_cin,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_sum,
    input  logic              alu_cout,
    output logic              res_valid,
    output logic [1:0]        res_rd,
    output logic [DATA_W-1:0] res_data,
    output logic              flag_z,
    output logic              flag_c,
    output logic              err,
    input  logic [1:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WB    = 2'd2;

    // Instruction opcodes (also used directly as ALU operation codes)
    localparam logic [3:0] OPC_SUB = 4'b0001;
    localparam logic [3:0] OPC_ADD = 4'b0010;
    localparam logic [3:0] OPC_AND = 4'b0011;
    localparam logic [3:0] OPC_XOR = 4'b0101;
    localparam logic [3:0] OPC_LDI = 4'b1000;
    localparam logic [3:0] OPC_NOP = 4'b1111;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic              started_q;      // first edge after reset release seen
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] alu_a_q, alu_b_q;
    logic [OP_W-1:0]   alu_op_q;
    logic              alu_cin_q;
    logic [3:0]        op_q;           // opcode of the instruction in flight
    logic [1:0]        rd_q;           // destination of the instruction in flight
    logic [DATA_W-1:0] result_q;       // value to be written back
    logic              carry_q;        // ALU carry sampled at end of ISSUE
    logic              flag_z_q, flag_c_q;
    logic              err_q;

    // ------------------------------------------------------------------------
    // Instruction field decode
    // ------------------------------------------------------------------------
    logic [3:0] w_op;
    logic [1:0] w_rd, w_rs;
    logic [7:0] w_imm;
    logic       w_is_alu, w_is_ldi, w_is_nop, w_is_illegal;
    logic       w_accept;

    assign w_op  = instr[15:12];
    assign w_rd  = instr[11:10];
    assign w_rs  = instr[9:8];
    assign w_imm = instr[7:0];

    // Classify the incoming opcode; anything not listed is illegal
    always_comb begin
        w_is_alu     = 1'b0;
        w_is_ldi     = 1'b0;
        w_is_nop     = 1'b0;
        w_is_illegal = 1'b0;
        case (w_op)
            OPC_SUB, OPC_ADD, OPC_AND, OPC_XOR: w_is_alu = 1'b1;
            OPC_LDI:                            w_is_ldi = 1'b1;
            OPC_NOP:                            w_is_nop = 1'b1;
            default:                            w_is_illegal = 1'b1;
        endcase
    end

    assign w_accept = instr_valid && instr_ready;

    // ------------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------------
    // Holds the FSM state; reset abandons any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------------
    // ALU ops go through ISSUE, LDI goes straight to WB, NOP/illegal stay idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_is_alu) begin
                        state_d = ST_ISSUE;
                    end else if (w_is_ldi) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ISSUE: state_d = ST_WB;
            ST_WB:    state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM process 3: outputs
    // ------------------------------------------------------------------------
    // Ready only in IDLE and only once the first post-reset edge has passed;
    // writeback outputs are driven only while the pulse is high
    always_comb begin
        instr_ready = 1'b0;
        res_valid   = 1'b0;
        res_rd      = 2'd0;
        res_data    = '0;
        case (state_q)
            ST_IDLE: instr_ready = started_q;
            ST_WB: begin
                res_valid = 1'b1;
                res_rd    = rd_q;
                res_data  = result_q;
            end
            default: begin
                instr_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: operand issue, result capture, writeback and flags
    // ------------------------------------------------------------------------
    // All architectural state and ALU-facing registers; cleared on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            alu_cin_q <= 1'b0;
            op_q      <= 4'd0;
            rd_q      <= 2'd0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            started_q <= 1'b1;
            // err is a single-cycle pulse following an illegal accept
            err_q     <= w_accept && w_is_illegal;

            case (state_q)
                ST_IDLE: begin
                    if (w_accept && (w_is_alu || w_is_ldi)) begin
                        op_q <= w_op;
                        rd_q <= w_rd;
                    end
                    if (w_accept && w_is_alu) begin
                        // rd==rs simply reads the same register twice
                        alu_a_q   <= regs_q[w_rd];
                        alu_b_q   <= regs_q[w_rs];
                        alu_op_q  <= OP_W'(w_op);
                        alu_cin_q <= (w_op == OPC_SUB);
                    end
                    if (w_accept && w_is_ldi) begin
                        result_q <= DATA_W'(w_imm);
                    end
                end
                ST_ISSUE: begin
                    // ALU inputs have been stable all cycle; capture its outputs
                    result_q <= alu_sum;
                    carry_q  <= alu_cout;
                end
                ST_WB: begin
                    regs_q[rd_q] <= result_q;
                    flag_z_q     <= (result_q == '0);
                    case (op_q)
                        OPC_ADD, OPC_SUB: flag_c_q <= carry_q;
                        OPC_XOR, OPC_AND: flag_c_q <= 1'b0;
                        default:          flag_c_q <= flag_c_q; // LDI keeps carry
                    endcase
                end
                default: begin
                    carry_q <= carry_q;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign alu_cin  = alu_cin_q;
    assign flag_z   = flag_z_q;
    assign flag_c   = flag_c_q;
    assign err      = err_q;
    assign dbg_data = regs_q[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Self-checking bench for alu_issue_ctrl with a behavioural
//               combinational ALU attached to the issue port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  alu_a, alu_b, alu_sum;
    logic        alu_cin, alu_cout;
    logic [3:0]  alu_op;
    logic        res_valid;
    logic [1:0]  res_rd;
    logic [7:0]  res_data;
    logic        flag_z, flag_c, err;
    logic [1:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int checks = 0;
    int errors = 0;

    alu_issue_ctrl #(.DATA_W(8), .NREGS(4), .OP_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
        .alu_sum(alu_sum), .alu_cout(alu_cout),
        .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data),
        .flag_z(flag_z), .flag_c(flag_c), .err(err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Behavioural ALU: SUB is a + ~b + cin
    always_comb begin
        {alu_cout, alu_sum} = 9'd0;
        case (alu_op)
            4'b0001: {alu_cout, alu_sum} = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, alu_cin};
            4'b0010: {alu_cout, alu_sum} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
            4'b0101: {alu_cout, alu_sum} = {1'b0, alu_a ^ alu_b};
            4'b0011: {alu_cout, alu_sum} = {1'b0, alu_a & alu_b};
            default: {alu_cout, alu_sum} = 9'd0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ins;
        logic        is_alu;
        logic [3:0]  op;
        logic        cin;
        logic [1:0]  rd;
        logic [7:0]  data;
        logic        z;
        logic        c;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!instr_ready && n < 10) begin
            step();
            n++;
        end
        chk("ready_timeout", {31'd0, instr_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        int hs, cyc, last;

        // {instr, is_alu, op, cin, rd, data, z, c}
        vt[0]  = '{16'h8005, 1'b0, 4'h0, 1'b0, 2'd0, 8'h05, 1'b0, 1'b0}; // LDI R0,05
        vt[1]  = '{16'h8403, 1'b0, 4'h0, 1'b0, 2'd1, 8'h03, 1'b0, 1'b0}; // LDI R1,03
        vt[2]  = '{16'h2100, 1'b1, 4'h2, 1'b0, 2'd0, 8'h08, 1'b0, 1'b0}; // ADD R0,R1
        vt[3]  = '{16'h88FF, 1'b0, 4'h0, 1'b0, 2'd2, 8'hFF, 1'b0, 1'b0}; // LDI R2,FF
        vt[4]  = '{16'h8C01, 1'b0, 4'h0, 1'b0, 2'd3, 8'h01, 1'b0, 1'b0}; // LDI R3,01
        vt[5]  = '{16'h2B00, 1'b1, 4'h2, 1'b0, 2'd2, 8'h00, 1'b1, 1'b1}; // ADD R2,R3
        vt[6]  = '{16'h1000, 1'b1, 4'h1, 1'b1, 2'd0, 8'h00, 1'b1, 1'b1}; // SUB R0,R0
        vt[7]  = '{16'h84F0, 1'b0, 4'h0, 1'b0, 2'd1, 8'hF0, 1'b0, 1'b1}; // LDI R1,F0 (c kept)
        vt[8]  = '{16'h88FF, 1'b0, 4'h0, 1'b0, 2'd2, 8'hFF, 1'b0, 1'b1}; // LDI R2,FF
        vt[9]  = '{16'h5600, 1'b1, 4'h5, 1'b0, 2'd1, 8'h0F, 1'b0, 1'b0}; // XOR R1,R2
        vt[10] = '{16'h3600, 1'b1, 4'h3, 1'b0, 2'd1, 8'h0F, 1'b0, 1'b0}; // AND R1,R2
        vt[11] = '{16'h1600, 1'b1, 4'h1, 1'b1, 2'd1, 8'h10, 1'b0, 1'b0}; // SUB R1,R2
        vt[12] = '{16'h2500, 1'b1, 4'h2, 1'b0, 2'd1, 8'h20, 1'b0, 1'b0}; // ADD R1,R1

        rst_n = 1'b1;
        instr_valid = 1'b0;
        instr = 16'h0000;
        dbg_addr = 2'd0;

        // ---------------- power-on reset ----------------
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", {31'd0, instr_ready}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_alu", {14'd0, alu_a, alu_b, alu_cin, alu_op[0]}, 32'd0);
        chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
        chk("rst_flags_err", {29'd0, flag_z, flag_c, err}, 32'd0);
        chk("rst_dbg_r0", {24'd0, dbg_data}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", {31'd0, instr_ready}, 32'd0);
        step();
        chk("ready_after_release", {31'd0, instr_ready}, 32'd1);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 13; i++) begin
            wait_ready();
            instr_valid = 1'b1;
            instr = vt[i].ins;
            step();
            instr_valid = 1'b0;
            instr = 16'h0000;
            if (vt[i].is_alu) begin
                chk($sformatf("v%0d_alu_op", i), {28'd0, alu_op}, {28'd0, vt[i].op});
                chk($sformatf("v%0d_alu_cin", i), {31'd0, alu_cin}, {31'd0, vt[i].cin});
            end
            lat = 1;
            while (!res_valid && lat < 5) begin
                step();
                lat++;
            end
            chk($sformatf("v%0d_latency", i), lat, vt[i].is_alu ? 32'd2 : 32'd1);
            chk($sformatf("v%0d_res_rd", i), {30'd0, res_rd}, {30'd0, vt[i].rd});
            chk($sformatf("v%0d_res_data", i), {24'd0, res_data}, {24'd0, vt[i].data});
            step();
            chk($sformatf("v%0d_pulse_end", i), {31'd0, res_valid}, 32'd0);
            chk($sformatf("v%0d_flags", i), {30'd0, flag_z, flag_c}, {30'd0, vt[i].z, vt[i].c});
            dbg_addr = vt[i].rd;
            #1;
            chk($sformatf("v%0d_dbg", i), {24'd0, dbg_data}, {24'd0, vt[i].data});
        end

        // ---------------- back-to-back ADD R3,R3 with valid held ----------------
        wait_ready();
        instr_valid = 1'b1;
        hs = 0; cyc = 0; last = -1;
        while (hs < 4 && cyc < 40) begin
            if (instr_ready) begin
                instr = 16'h2F00;
                if (last >= 0) chk("hs_gap", cyc - last, 32'd3);
                last = cyc;
                hs++;
            end else begin
                instr = 16'h8CAA; // must be ignored while busy
            end
            step();
            cyc++;
        end
        instr_valid = 1'b0;
        instr = 16'h0000;
        chk("hs_count", hs, 32'd4);
        wait_ready();
        dbg_addr = 2'd3;
        #1;
        chk("b2b_r3", {24'd0, dbg_data}, 32'h10);
        chk("b2b_flags", {30'd0, flag_z, flag_c}, 32'd0);

        // ---------------- illegal opcode and NOP ----------------
        instr_valid = 1'b1; instr = 16'h8000; // LDI R0,00 -> z=1
        step();
        instr_valid = 1'b0;
        wait_ready();
        chk("ldi0_flags", {30'd0, flag_z, flag_c}, 32'd2);
        instr_valid = 1'b1; instr = 16'h7000; // illegal
        step();
        instr_valid = 1'b0;
        chk("ill_err", {31'd0, err}, 32'd1);
        chk("ill_no_res", {31'd0, res_valid}, 32'd0);
        chk("ill_ready", {31'd0, instr_ready}, 32'd1);
        step();
        chk("ill_err_pulse", {31'd0, err}, 32'd0);
        chk("ill_flags", {30'd0, flag_z, flag_c}, 32'd2);
        dbg_addr = 2'd3;
        #1;
        chk("ill_r3", {24'd0, dbg_data}, 32'h10);
        instr_valid = 1'b1; instr = 16'hF000; // NOP
        step();
        instr_valid = 1'b0;
        chk("nop_ready", {31'd0, instr_ready}, 32'd1);
        chk("nop_quiet", {30'd0, res_valid, err}, 32'd0);
        step();
        chk("nop_quiet2", {30'd0, res_valid, err}, 32'd0);

        // ---------------- reset mid-ISSUE of ADD R2,R3 ----------------
        wait_ready();
        instr_valid = 1'b1; instr = 16'h2B00;
        step();
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("mid_rst_alu", {15'd0, alu_a, alu_b, alu_cin}, 32'd0);
        chk("mid_rst_alu_op", {28'd0, alu_op}, 32'd0);
        chk("mid_rst_flags_err", {29'd0, flag_z, flag_c, err}, 32'd0);
        chk("mid_rst_res", {22'd0, res_rd, res_data}, 32'd0);
        chk("mid_rst_ready", {31'd0, instr_ready}, 32'd0);
        dbg_addr = 2'd2;
        #1;
        chk("mid_rst_r2", {24'd0, dbg_data}, 32'd0);
        step();
        chk("mid_rst_no_wb", {31'd0, res_valid}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("mid_rst_ready_after", {31'd0, instr_ready}, 32'd1);
        chk("mid_rst_no_wb2", {31'd0, res_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
